// File: rtl/div_unit.sv
// div_unit: sequential signed divider for the multicycle MIPS datapath (DIV).
// Restoring division on operand magnitudes, one quotient bit per cycle,
// followed by a sign fix-up cycle. The quotient goes to LO and the remainder
// goes to HI through the downstream HI/LO select mux.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             zero_div;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             no_borrow;

  // Operand magnitudes and the trial subtraction for the current iteration;
  // the most negative value maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    dvd_abs   = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_abs   = divisor[WIDTH-1]  ? -divisor  : divisor;
    rem_shift = {rem, quo[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_mag};
    no_borrow = (rem_shift >= {1'b0, dvs_mag});
  end

  // Control FSM plus datapath registers; every output is driven from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      lo_out   <= '0;
      hi_out   <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs_mag  <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      zero_div <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            quo      <= dvd_abs;
            dvs_mag  <= dvs_abs;
            q_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg    <= dividend[WIDTH-1];
            rem      <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
            zero_div <= (divisor == '0);
            state    <= (divisor == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          busy <= 1'b1;
          if (no_borrow) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (zero_div) begin
            div_zero <= 1'b1;
          end else begin
            lo_out <= q_neg ? -quo : quo;
            hi_out <= r_neg ? -rem : rem;
          end
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Stimulus pushes the expected
// result, its completion cycle and its busy length; a monitor pops on done.
module tb_div_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] hi_out;
  logic             div_zero;

  typedef struct {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             dz;
    int               due;
    int               busy_len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .lo_out   (lo_out),
    .hi_out   (hi_out),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: counts busy cycles and checks every done pulse against the queue head.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("lo_out", lo_out, e.lo);
        checkOutput("hi_out", hi_out, e.hi);
        checkOutput("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
        checkOutput("done_cycle", cyc, e.due);
        checkOutput("busy_cycles", busy_cnt, e.busy_len);
        checkOutput("busy_with_done", {31'b0, busy}, 32'd0);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end
  end

  // Issue one division; optionally poke start with 1/1 while busy.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi,
                               input logic dz, input int poke_at);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.lo = lo;
    e.hi = hi;
    e.dz = dz;
    e.due = cyc + 1 + ((b == '0) ? 1 : WIDTH + 1);
    e.busy_len = (b == '0) ? 0 : WIDTH;
    exp_q.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    for (int k = 1; k < 80 && exp_q.size() != 0; k++) begin
      if (poke_at != 0 && k == poke_at) begin
        start    = 1'b1;
        dividend = 32'd1;
        divisor  = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done expected done by cycle %0d", e.due);
      exp_q.delete();
    end
  endtask

  initial begin
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_lo", lo_out, 32'd0);
    checkOutput("reset_hi", hi_out, 32'd0);
    checkOutput("reset_dz", {31'b0, div_zero}, 32'd0);
    reset = 1'b0;

    $display("[TB] basic and sign cases");
    applyStimulus(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 0);
    applyStimulus(-32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0);
    applyStimulus(32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1, 1'b0, 0);
    applyStimulus(-32'sd7, -32'sd2, 32'd3, 32'hFFFFFFFF, 1'b0, 0);

    $display("[TB] extremes");
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 0);
    applyStimulus(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b0, 0);
    applyStimulus(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 0);

    $display("[TB] divide by zero");
    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    applyStimulus(32'd55, 32'd0, 32'd14, 32'd2, 1'b1, 0);
    applyStimulus(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

    $display("[TB] start while busy");
    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 9);
    repeat (40) @(negedge clk);

    $display("[TB] reset mid-operation");
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
    checkOutput("midreset_done", {31'b0, done}, 32'd0);
    checkOutput("midreset_lo", lo_out, 32'd0);
    checkOutput("midreset_hi", hi_out, 32'd0);
    reset = 1'b0;
    applyStimulus(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 0);
    repeat (40) @(negedge clk);

    $display("[TB] random signed pairs");
    for (int i = 0; i < 1000; i++) begin
      sa = $urandom;
      if (i % 2 == 0) sb = $urandom;
      else sb = $signed($urandom_range(0, 200)) - 32'sd100;
      if (sb == 0) sb = 32'sd13;
      if (sa == 32'sh80000000 && sb == -32'sd1) sb = 32'sd3;
      applyStimulus(sa, sb, sa / sb, sa % sb, 1'b0, 0);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
